// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline stage register with a 2-entry skid buffer, valid/ready
// handshake, synchronous flush and memory side-effect suppression by instruction type.
module pipe_stage_skid #(
    parameter int unsigned       DATA_W      = 96,
    parameter int unsigned       TYPE_W      = 4,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0,
    parameter logic [TYPE_W-1:0] KILL_T0     = TYPE_W'(4'b1011),
    parameter logic [TYPE_W-1:0] KILL_T1     = TYPE_W'(4'b0101),
    parameter logic [TYPE_W-1:0] KILL_T2     = TYPE_W'(4'b0110)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_payload,
    input  logic [TYPE_W-1:0] in_type,
    input  logic              in_reg_wr_en,
    input  logic              in_is_load,
    input  logic              in_is_store,
    output logic              mem_suppress,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_payload,
    output logic [TYPE_W-1:0] out_type,
    output logic              out_reg_wr_en,
    output logic              out_is_load,
    output logic              out_is_store,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic [DATA_W-1:0] payload;
        logic [TYPE_W-1:0] typ;
        logic              reg_wr_en;
        logic              is_load;
        logic              is_store;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   accept;
    logic   pop;

    // Suppression is decoded from the incoming type and baked in at capture time.
    assign mem_suppress = (in_type == KILL_T0) || (in_type == KILL_T1) || (in_type == KILL_T2);

    always_comb begin
        in_entry.payload   = in_payload;
        in_entry.typ       = in_type;
        in_entry.reg_wr_en = in_reg_wr_en;
        in_entry.is_load   = in_is_load & ~mem_suppress;
        in_entry.is_store  = in_is_store & ~mem_suppress;
    end

    // Ready is a function of held state only, so it never loops back through out_ready.
    assign in_ready  = (state_q != ST_TWO) & ~reset;
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (reset) begin
            state_d           = ST_EMPTY;
            main_d.payload    = RESET_VALUE;
            main_d.typ        = RESET_VALUE[TYPE_W-1:0];
            main_d.reg_wr_en  = 1'b0;
            main_d.is_load    = 1'b0;
            main_d.is_store   = 1'b0;
            skid_d            = '0;
        end else if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_d = in_entry;
                    end else if (accept) begin
                        skid_d  = in_entry;
                        state_d = ST_TWO;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
    end

    // Control outputs are gated so a bubble never causes a side-effect.
    assign out_payload   = main_q.payload;
    assign out_type      = main_q.typ;
    assign out_reg_wr_en = out_valid & main_q.reg_wr_en;
    assign out_is_load   = out_valid & main_q.is_load;
    assign out_is_store  = out_valid & main_q.is_store;
    assign occupancy     = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomised self-checking bench for pipe_stage_skid.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [95:0] in_payload, out_payload;
    logic [3:0]  in_type, out_type;
    logic        in_reg_wr_en, in_is_load, in_is_store, mem_suppress;
    logic        out_reg_wr_en, out_is_load, out_is_store;
    logic [1:0]  occupancy;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [95:0] payload;
        logic [3:0]  typ;
        logic        wr;
        logic        ld;
        logic        st;
    } exp_t;

    pipe_stage_skid dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
        .in_type(in_type), .in_reg_wr_en(in_reg_wr_en), .in_is_load(in_is_load),
        .in_is_store(in_is_store), .mem_suppress(mem_suppress),
        .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
        .out_type(out_type), .out_reg_wr_en(out_reg_wr_en), .out_is_load(out_is_load),
        .out_is_store(out_is_store), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic is_kill(input logic [3:0] t);
        return (t == 4'b1011) || (t == 4'b0101) || (t == 4'b0110);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [95:0] p, input logic [3:0] t,
                         input logic wr, input logic ld, input logic st);
        in_valid     = v;
        in_payload   = p;
        in_type      = t;
        in_reg_wr_en = wr;
        in_is_load   = ld;
        in_is_store  = st;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0, 4'h0, 1'b0, 1'b0, 1'b0);
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        step(); step();
        tests++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin fails++;
            $display("FAIL reset_state valid %b occ %0d exp 0 0", out_valid, occupancy); end
        tests++; if (out_payload !== 96'h0 || out_type !== 4'h0) begin fails++;
            $display("FAIL reset_data payload %h type %h exp 0 0", out_payload, out_type); end
        tests++; if ({out_reg_wr_en, out_is_load, out_is_store} !== 3'b000) begin fails++;
            $display("FAIL reset_ctrl got %b exp 000", {out_reg_wr_en, out_is_load, out_is_store}); end
        reset = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 96'(i), 4'h0, 1'b1, 1'b0, 1'b0);
            step();
            tests++; if (out_valid !== 1'b1 || out_payload !== 96'(i)) begin fails++;
                $display("FAIL stream_out[%0d] valid %b payload %h exp 1 %h", i, out_valid, out_payload, 96'(i)); end
            tests++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin fails++;
                $display("FAIL stream_occ[%0d] occ %0d ready %b exp 1 1", i, occupancy, in_ready); end
        end
        drive(1'b0, '0, 4'h0, 1'b0, 1'b0, 1'b0);
        step();
        tests++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_reg_wr_en !== 1'b0) begin fails++;
            $display("FAIL stream_drain valid %b occ %0d wr %b exp 0 0 0", out_valid, occupancy, out_reg_wr_en); end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        drive(1'b1, 96'hA, 4'h0, 1'b0, 1'b0, 1'b0);
        step();
        tests++; if (occupancy !== 2'd1 || out_payload !== 96'hA) begin fails++;
            $display("FAIL bp_first occ %0d payload %h exp 1 a", occupancy, out_payload); end
        drive(1'b1, 96'hB, 4'h0, 1'b0, 1'b0, 1'b0);
        step();
        tests++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_payload !== 96'hA) begin fails++;
            $display("FAIL bp_full occ %0d ready %b payload %h exp 2 0 a", occupancy, in_ready, out_payload); end
        drive(1'b1, 96'hC, 4'h0, 1'b0, 1'b0, 1'b0);
        step();
        tests++; if (occupancy !== 2'd2 || out_payload !== 96'hA) begin fails++;
            $display("FAIL bp_hold occ %0d payload %h exp 2 a", occupancy, out_payload); end
        out_ready = 1'b1;
        step();
        tests++; if (occupancy !== 2'd1 || out_payload !== 96'hB || in_ready !== 1'b1) begin fails++;
            $display("FAIL bp_drain_b occ %0d payload %h ready %b exp 1 b 1", occupancy, out_payload, in_ready); end
        step();
        tests++; if (occupancy !== 2'd1 || out_payload !== 96'hC) begin fails++;
            $display("FAIL bp_drain_c occ %0d payload %h exp 1 c", occupancy, out_payload); end
        drive(1'b0, '0, 4'h0, 1'b0, 1'b0, 1'b0);
        step();
        tests++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin fails++;
            $display("FAIL bp_empty occ %0d valid %b exp 0 0", occupancy, out_valid); end
    endtask

    task automatic test_suppress();
        out_ready = 1'b1;
        drive(1'b1, 96'h51, 4'b0101, 1'b1, 1'b1, 1'b0);
        #1;
        tests++; if (mem_suppress !== 1'b1) begin fails++; $display("FAIL sup_flag_0101 got %b exp 1", mem_suppress); end
        step();
        tests++; if (out_is_load !== 1'b0 || out_reg_wr_en !== 1'b1 || out_type !== 4'b0101) begin fails++;
            $display("FAIL sup_load ld %b wr %b type %b exp 0 1 0101", out_is_load, out_reg_wr_en, out_type); end
        drive(1'b1, 96'h52, 4'b0010, 1'b0, 1'b0, 1'b1);
        #1;
        tests++; if (mem_suppress !== 1'b0) begin fails++; $display("FAIL sup_flag_0010 got %b exp 0", mem_suppress); end
        step();
        tests++; if (out_is_store !== 1'b1 || out_reg_wr_en !== 1'b0) begin fails++;
            $display("FAIL sup_pass_store st %b wr %b exp 1 0", out_is_store, out_reg_wr_en); end
        drive(1'b1, 96'h53, 4'b1011, 1'b0, 1'b0, 1'b1);
        step();
        tests++; if (out_is_store !== 1'b0 || out_payload !== 96'h53) begin fails++;
            $display("FAIL sup_store_1011 st %b payload %h exp 0 53", out_is_store, out_payload); end
        drive(1'b1, 96'h54, 4'b0110, 1'b0, 1'b1, 1'b1);
        step();
        tests++; if ({out_is_load, out_is_store} !== 2'b00) begin fails++;
            $display("FAIL sup_0110 got %b exp 00", {out_is_load, out_is_store}); end
        drive(1'b1, 96'h55, 4'b0111, 1'b1, 1'b1, 1'b1);
        step();
        tests++; if ({out_reg_wr_en, out_is_load, out_is_store} !== 3'b111) begin fails++;
            $display("FAIL sup_0111 got %b exp 111", {out_reg_wr_en, out_is_load, out_is_store}); end
        drive(1'b0, '0, 4'h0, 1'b0, 1'b0, 1'b0);
        step();
        tests++; if ({out_reg_wr_en, out_is_load, out_is_store} !== 3'b000 || out_payload !== 96'h55) begin fails++;
            $display("FAIL sup_bubble ctrl %b payload %h exp 000 55", {out_reg_wr_en, out_is_load, out_is_store}, out_payload); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 96'hD, 4'h0, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 96'hE, 4'h0, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b1, 96'hF, 4'h0, 1'b1, 1'b1, 1'b1);
        flush = 1'b1;
        step();
        tests++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++;
            $display("FAIL flush_two occ %0d valid %b ready %b exp 0 0 1", occupancy, out_valid, in_ready); end
        tests++; if ({out_reg_wr_en, out_is_load, out_is_store} !== 3'b000 || out_payload !== 96'hD) begin fails++;
            $display("FAIL flush_two_out ctrl %b payload %h exp 000 d", {out_reg_wr_en, out_is_load, out_is_store}, out_payload); end
        // Flush from ONE while an input is accepted: the input must vanish too.
        flush = 1'b0;
        drive(1'b1, 96'h10, 4'h0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 96'h20, 4'h0, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, '0, 4'h0, 1'b0, 1'b0, 1'b0);
        step();
        tests++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_payload !== 96'h10) begin fails++;
            $display("FAIL flush_one occ %0d valid %b payload %h exp 0 0 10", occupancy, out_valid, out_payload); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 96'h11, 4'b0010, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 96'h22, 4'b0010, 1'b1, 1'b0, 1'b0);
        step();
        tests++; if (occupancy !== 2'd2) begin fails++; $display("FAIL rmid_fill occ %0d exp 2", occupancy); end
        drive(1'b1, 96'h33, 4'b0010, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rmid_ready_in_reset got %b exp 0", in_ready); end
        step();
        tests++; if (out_payload !== 96'h0 || out_type !== 4'h0 || out_valid !== 1'b0 || occupancy !== 2'd0) begin fails++;
            $display("FAIL rmid_state payload %h type %h valid %b occ %0d exp 0 0 0 0", out_payload, out_type, out_valid, occupancy); end
        reset = 1'b0;
        drive(1'b0, '0, 4'h0, 1'b0, 1'b0, 1'b0);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready_after got %b exp 1", in_ready); end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        logic holding = 1'b0;
        logic acc, pp, r0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            tests++; if (out_valid !== (q.size() > 0) || occupancy !== 2'(q.size())) begin fails++;
                $display("FAIL rnd_occ[%0d] valid %b occ %0d exp %0d", cyc, out_valid, occupancy, q.size()); end
            if (q.size() > 0) begin
                tests++;
                if (out_payload !== q[0].payload || out_type !== q[0].typ ||
                    {out_reg_wr_en, out_is_load, out_is_store} !== {q[0].wr, q[0].ld, q[0].st}) begin
                    fails++;
                    $display("FAIL rnd_data[%0d] got %h/%h/%b exp %h/%h/%b", cyc, out_payload, out_type,
                             {out_reg_wr_en, out_is_load, out_is_store}, q[0].payload, q[0].typ, {q[0].wr, q[0].ld, q[0].st});
                end
            end
            if (!holding) begin
                drive(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom}, 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            r0 = in_ready;
            out_ready = ~out_ready;
            #1;
            tests++; if (in_ready !== r0 || r0 !== (q.size() < 2)) begin fails++;
                $display("FAIL rnd_ready[%0d] got %b/%b exp %b", cyc, r0, in_ready, q.size() < 2); end
            out_ready = ~out_ready;
            acc = in_valid && (q.size() < 2);
            pp  = (q.size() > 0) && out_ready;
            holding = in_valid && !acc;
            e = '{in_payload, in_type, in_reg_wr_en,
                  in_is_load & ~is_kill(in_type), in_is_store & ~is_kill(in_type)};
            step();
            if (pp)  void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        drive(1'b0, '0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_pressure();
        test_suppress();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, back-pressure-capable pipeline stage register. It is the successor to the fixed EX/MEM register.
- Carries a generic payload plus control fields (reg-write, load, store, instruction type) through a 2-entry skid buffer with a valid/ready handshake and synchronous flush.
- Suppresses memory side-effects for configurable multicycle instruction types.
- Sits between any two pipeline stages: EX/MEM, MEM/WB, or multiplier writeback.

Parameters:
- DATA_W, 96: payload width in bits (default = ALU out + data2 + PC).
- TYPE_W, 4: instruction-type field width.
- RESET_VALUE, 0: reset value of out_payload and out_type.
- KILL_T0, 4'b1011: instruction type whose load/store is suppressed.
- KILL_T1, 4'b0101: as above.
- KILL_T2, 4'b0110: as above.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: synchronous, active-high.
- flush, input, 1: synchronous, kills all held entries.
- in_valid, input, 1: upstream entry valid.
- in_ready, output, 1: stage can accept this cycle.
- in_payload, input, DATA_W: data fields.
- in_type, input, TYPE_W: instruction type.
- in_reg_wr_en, input, 1: register-file write enable.
- in_is_load, input, 1: load op.
- in_is_store, input, 1: store op.
- mem_suppress, output, 1: combinational; 1 when in_type equals KILL_T0, KILL_T1 or KILL_T2.
- out_valid, output, 1: output entry valid.
- out_ready, input, 1: downstream accepts.
- out_payload, output, DATA_W: held payload.
- out_type, output, TYPE_W: held type.
- out_reg_wr_en, output, 1: gated by out_valid.
- out_is_load, output, 1: gated by out_valid.
- out_is_store, output, 1: gated by out_valid.
- occupancy, output, 2: number of held entries, 0..2.

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk.
- Handshake:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_valid and the input fields must be held stable until accepted; the stage never drops an accepted entry.
- in_ready: 1 when the skid entry is empty, 0 while reset=1. It depends only on registered state, never on out_ready in the same cycle.
- Storage: main entry (drives outputs) and skid entry.
- States:
  - EMPTY (occupancy 0)
  - ONE (main full)
  - TWO (main + skid full)
- Transitions:
  - EMPTY: accept -> ONE; input captured into main.
  - ONE:
    - accept & pop -> ONE; main reloaded from input.
    - accept & !pop -> TWO; input captured into skid.
    - !accept & pop -> EMPTY.
    - otherwise hold.
  - TWO (in_ready=0):
    - pop -> ONE; skid moves to main, skid cleared.
    - otherwise hold.
- Latency 1 cycle: an entry accepted at edge N is visible on the outputs after edge N.
- Throughput: 1 entry/cycle sustained when out_ready=1. Strict FIFO order is kept.
- Capture rule, applied identically for main and skid:
  - stored is_load = in_is_load & ~mem_suppress.
  - stored is_store = in_is_store & ~mem_suppress.
  - stored reg_wr_en = in_reg_wr_en; it is not suppressed.
- Output gating:
  - out_reg_wr_en, out_is_load and out_is_store are 0 whenever out_valid=0, so a bubble produces no side-effects.
  - out_payload and out_type hold their last value when invalid.
  - occupancy reflects registered state.
- flush:
  - Next state is EMPTY regardless of accept or pop.
  - An entry presented in the flush cycle is discarded, even though in_ready=1 and in_valid=1 were high in that cycle.
  - out_payload and out_type hold their value.
- Priority: reset > flush > normal.
- Reset (synchronous, including mid-transfer): next cycle state EMPTY and out_valid=0.
  - out_payload and out_type = RESET_VALUE.
  - All control outputs 0, occupancy 0.
  - in_ready=1 after reset deasserts.

Test Plan:
1. Streaming: reset, then 5 consecutive payloads 0x1..0x5 with out_ready=1 -> outputs 0x1..0x5 on consecutive cycles, 1-cycle latency, occupancy stays 1, in_ready stays 1.
2. Back-pressure: out_ready=0, send 0xA, 0xB, 0xC -> 0xA and 0xB accepted, occupancy=2, in_ready=0, 0xC held upstream. Then raise out_ready -> 0xA, 0xB, 0xC emerge in order with no loss or duplicate.
3. Suppression: in_type=4'b0101, in_is_load=1, in_reg_wr_en=1 -> out_is_load=0, out_reg_wr_en=1, mem_suppress=1. Then in_type=4'b0010 with in_is_store=1 -> out_is_store=1, mem_suppress=0.
4. Flush in TWO with in_valid=1 -> next cycle occupancy=0, out_valid=0, all control outputs 0, input entry discarded, in_ready=1.
5. Reset mid-transfer in state TWO -> next cycle out_payload=0, out_type=0, out_valid=0, occupancy=0. in_ready=0 during reset, 1 after.
6. Random valid/ready toggling, 1000 cycles, scoreboard check -> output sequence equals accepted sequence (with suppression applied), and in_ready never depends combinationally on out_ready.
